alu_issue_stage: RTL and testbench

Front end of the 4-bit datapath: accepts 9-bit instructions through a valid/ready handshake, buffers them in a small FIFO, reads operands from a 4×4-bit register file and drives `sel`/`rs`/`rt` into the combinational `Decode_and_Execute` ALU. The ALU result `rd` is written back into the register file one edge later. A bypass path resolves back-to-back dependencies without stalling. Sustained throughput is one instruction per cycle.

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/alu_issue_stage.sv | 124 ++++++++++++
 tb/tb_alu_issue_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU issue front end: field layout,
// opcode encoding and the packed instruction type.
package alu_pkg;

  localparam int DATA_W   = 4;
  localparam int REG_AW   = 2;
  localparam int NUM_REGS = 4;
  localparam int OP_W     = 3;
  localparam int INSTR_W  = 9;

  // Field offsets inside the 9-bit instruction word
  localparam int OP_LSB   = 6;
  localparam int DST_LSB  = 4;
  localparam int SRC1_LSB = 2;
  localparam int SRC2_LSB = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_ROL = 3'b100,
    OP_ASR = 3'b101,
    OP_EQ  = 3'b110,
    OP_GT  = 3'b111
  } opcode_e;

  typedef struct packed {
    opcode_e             op;
    logic [REG_AW-1:0]   dst;
    logic [REG_AW-1:0]   src1;
    logic [REG_AW-1:0]   src2;
  } instr_t;

  // Operand source choice: the live EX result overrides the register file
  // when the EX instruction is about to write the register being read.
  function automatic logic [DATA_W-1:0] operand_sel(
    input logic                ex_live,
    input logic [REG_AW-1:0]   ex_dst,
    input logic [REG_AW-1:0]   src,
    input logic [DATA_W-1:0]   ex_result,
    input logic [DATA_W-1:0]   rf_value
  );
    logic [DATA_W-1:0] val;
    if (ex_live && (ex_dst == src)) begin
      val = ex_result;
    end else begin
      val = rf_value;
    end
    return val;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head entry is visible on rdata
// whenever the FIFO is not empty. Overflowing pushes and underflowing pops
// are ignored.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_s;
  logic             pop_s;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                  (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;
  assign rdata  = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values and storage contents
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer and storage registers; reset empties the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage of the 4-bit datapath: instruction FIFO, 4x4 register file,
// EX register feeding the external combinational ALU, single-entry bypass
// from the EX result, and writeback of that result one edge later.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INSTR_W-1:0]  instr_in,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                hold,
  input  logic                ld_en,
  input  logic [REG_AW-1:0]   ld_addr,
  input  logic [DATA_W-1:0]   ld_data,
  output logic [OP_W-1:0]     sel,
  output logic [DATA_W-1:0]   rs,
  output logic [DATA_W-1:0]   rt,
  input  logic [DATA_W-1:0]   rd,
  output logic                ex_valid,
  output logic [REG_AW-1:0]   wb_dst,
  input  logic [REG_AW-1:0]   dbg_addr,
  output logic [DATA_W-1:0]   dbg_data
);

  logic [INSTR_W-1:0] head_raw_s;
  instr_t             head_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               push_s;
  logic               pop_s;

  opcode_e            sel_q, sel_d;
  logic [DATA_W-1:0]  rs_q, rs_d;
  logic [DATA_W-1:0]  rt_q, rt_d;
  logic [REG_AW-1:0]  wb_dst_q, wb_dst_d;
  logic               ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0]  rf_q [NUM_REGS];
  logic [DATA_W-1:0]  rf_d [NUM_REGS];

  // A full FIFO refuses a push even if a pop frees a slot on the same edge
  assign push_s = instr_valid && !fifo_full_s;
  assign pop_s  = !fifo_empty_s && !hold;
  assign head_s = instr_t'(head_raw_s);

  sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (instr_in),
    .rdata (head_raw_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // EX register load: popped instruction reads RF (pre-write values) or bypasses rd
  always_comb begin
    sel_d      = sel_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    wb_dst_d   = wb_dst_q;
    ex_valid_d = pop_s;
    if (pop_s) begin
      sel_d    = head_s.op;
      wb_dst_d = head_s.dst;
      rs_d     = operand_sel(ex_valid_q, wb_dst_q, head_s.src1, rd, rf_q[head_s.src1]);
      rt_d     = operand_sel(ex_valid_q, wb_dst_q, head_s.src2, rd, rf_q[head_s.src2]);
    end else begin
      sel_d    = sel_q;
      wb_dst_d = wb_dst_q;
      rs_d     = rs_q;
      rt_d     = rt_q;
    end
  end

  // Register file next state: writeback beats a preload to the same address
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ex_valid_q && (wb_dst_q == REG_AW'(i))) begin
        rf_d[i] = rd;
      end else if (ld_en && (ld_addr == REG_AW'(i))) begin
        rf_d[i] = ld_data;
      end else begin
        rf_d[i] = rf_q[i];
      end
    end
  end

  // EX register and register file state; reset drops any in-flight work
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q      <= OP_ADD;
      rs_q       <= {DATA_W{1'b0}};
      rt_q       <= {DATA_W{1'b0}};
      wb_dst_q   <= {REG_AW{1'b0}};
      ex_valid_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      sel_q      <= sel_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      wb_dst_q   <= wb_dst_d;
      ex_valid_q <= ex_valid_d;
      rf_q       <= rf_d;
    end
  end

  assign instr_ready = !fifo_full_s;
  assign sel         = sel_q;
  assign rs          = rs_q;
  assign rt          = rt_q;
  assign wb_dst      = wb_dst_q;
  assign ex_valid    = ex_valid_q;
  assign dbg_data    = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: drives directed instruction
// sequences, supplies the ALU result, and checks every cycle against a
// program-order model of the issue stage.
module tb_alu_issue_stage;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [8:0] instr_in;
  logic       instr_valid;
  logic       instr_ready;
  logic       hold;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [3:0] ld_data;
  logic [2:0] sel;
  logic [3:0] rs;
  logic [3:0] rt;
  logic [3:0] rd;
  logic       ex_valid;
  logic [1:0] wb_dst;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;

  int tests = 0;
  int fails = 0;

  alu_issue_stage #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .hold        (hold),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .sel         (sel),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .ex_valid    (ex_valid),
    .wb_dst      (wb_dst),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference ALU semantics (also acts as the external ALU)
  function automatic logic [3:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return {a[2:0], a[3]};
      3'd5: return {b[3], b[3:1]};
      3'd6: return (a == b) ? 4'd1 : 4'd0;
      default: return (a > b) ? 4'd1 : 4'd0;
    endcase
  endfunction

  assign rd = alu_ref(sel, rs, rt);

  function automatic logic [8:0] mk(input logic [2:0] op, input int d, input int s1, input int s2);
    return {op, 2'(d), 2'(s1), 2'(s2)};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- program-order model ----------------
  logic [8:0] m_q[$];
  logic [3:0] m_rf [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic       m_ex_v = 1'b0;
  logic [2:0] m_sel = 3'd0;
  logic [1:0] m_dst = 2'd0;
  logic [3:0] m_a = 4'd0;
  logic [3:0] m_b = 4'd0;
  bit         m_push, m_pop;
  logic [3:0] m_res, m_na, m_nb;
  logic [8:0] m_head;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      for (int i = 0; i < 4; i++) m_rf[i] = 4'd0;
      m_ex_v = 1'b0; m_sel = 3'd0; m_dst = 2'd0; m_a = 4'd0; m_b = 4'd0;
    end else begin
      m_push = instr_valid && (m_q.size() < DEPTH);
      m_pop  = (m_q.size() != 0) && !hold;
      m_res  = alu_ref(m_sel, m_a, m_b);
      if (m_pop) begin
        m_head = m_q.pop_front();
        // operand = newest value in program order (older EX result if it targets the source)
        m_na = (m_ex_v && m_dst == m_head[3:2]) ? m_res : m_rf[m_head[3:2]];
        m_nb = (m_ex_v && m_dst == m_head[1:0]) ? m_res : m_rf[m_head[1:0]];
      end
      if (ld_en) m_rf[ld_addr] = ld_data;
      if (m_ex_v) m_rf[m_dst] = m_res;
      if (m_pop) begin
        m_sel = m_head[8:6]; m_dst = m_head[5:4]; m_a = m_na; m_b = m_nb;
      end
      m_ex_v = m_pop;
      if (m_push) m_q.push_back(instr_in);
    end
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    check("ready",    {7'd0, instr_ready}, {7'd0, (m_q.size() < DEPTH)});
    check("ex_valid", {7'd0, ex_valid},    {7'd0, m_ex_v});
    check("sel",      {5'd0, sel},         {5'd0, m_sel});
    check("rs",       {4'd0, rs},          {4'd0, m_a});
    check("rt",       {4'd0, rt},          {4'd0, m_b});
    check("wb_dst",   {6'd0, wb_dst},      {6'd0, m_dst});
    check("dbg_data", {4'd0, dbg_data},    {4'd0, m_rf[dbg_addr]});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_is(input string name, input int a, input logic [3:0] exp);
    dbg_addr = 2'(a);
    #1;
    check(name, {4'd0, dbg_data}, {4'd0, exp});
  endtask

  initial begin
    rst = 1'b1; instr_in = 9'd0; instr_valid = 1'b0; hold = 1'b0;
    ld_en = 1'b0; ld_addr = 2'd0; ld_data = 4'd0; dbg_addr = 2'd0;
    step(); step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_ready", {7'd0, instr_ready}, 8'd1);
    check("rst_exv",   {7'd0, ex_valid},    8'd0);
    for (int i = 0; i < 4; i++) reg_is("rst_rf", i, 4'd0);

    // Preload r1=3, r2=5, then ADD r3,r1,r2
    ld_en = 1'b1; ld_addr = 2'd1; ld_data = 4'd3; step();
    ld_addr = 2'd2; ld_data = 4'd5; step();
    ld_en = 1'b0;
    instr_in = mk(3'b000, 3, 1, 2); instr_valid = 1'b1; step();
    instr_valid = 1'b0; step();
    check("add_exv", {7'd0, ex_valid}, 8'd1);
    check("add_sel", {5'd0, sel}, 8'd0);
    check("add_rs",  {4'd0, rs},  8'd3);
    check("add_rt",  {4'd0, rt},  8'd5);
    step();
    reg_is("add_r3", 3, 4'd8);

    // Dependency chain from an all-zero RF
    rst = 1'b1; step(); rst = 1'b0; step();
    instr_in = mk(3'b110, 1, 0, 0); instr_valid = 1'b1; step();
    instr_in = mk(3'b000, 1, 1, 1); step();
    check("chain_exv0", {7'd0, ex_valid}, 8'd1);
    instr_in = mk(3'b100, 2, 1, 0); step();
    check("chain_exv1", {7'd0, ex_valid}, 8'd1);
    check("chain_byp_rs", {4'd0, rs}, 8'd1);
    check("chain_byp_rt", {4'd0, rt}, 8'd1);
    instr_valid = 1'b0; step();
    check("chain_exv2", {7'd0, ex_valid}, 8'd1);
    step();
    reg_is("chain_r1", 1, 4'd2);
    reg_is("chain_r2", 2, 4'd4);

    // Hold with a full FIFO; refused 5th offer; drain in order
    hold = 1'b1;
    instr_in = mk(3'b011, 3, 1, 2); instr_valid = 1'b1; step();
    instr_in = mk(3'b001, 0, 2, 1); step();
    instr_in = mk(3'b010, 3, 3, 2); step();
    instr_in = mk(3'b101, 1, 0, 0); step();
    check("full_ready", {7'd0, instr_ready}, 8'd0);
    instr_in = mk(3'b110, 2, 0, 0); step();
    check("full_ready2", {7'd0, instr_ready}, 8'd0);
    instr_valid = 1'b0; hold = 1'b0; step();
    check("drain_sel0", {5'd0, sel}, 8'h03);
    step();
    check("drain_sel1", {5'd0, sel}, 8'h01);
    step();
    check("drain_sel2", {5'd0, sel}, 8'h02);
    step();
    check("drain_sel3", {5'd0, sel}, 8'h05);
    check("drain_exv3", {7'd0, ex_valid}, 8'd1);
    step();
    check("drain_exv4", {7'd0, ex_valid}, 8'd0);
    reg_is("drain_r3", 3, 4'd4);
    reg_is("drain_r1", 1, 4'd1);
    reg_is("drain_r2", 2, 4'd4);

    // Same-cycle preload and writeback to r2: writeback wins
    ld_en = 1'b1; ld_addr = 2'd1; ld_data = 4'd3; step();
    ld_en = 1'b0;
    instr_in = mk(3'b000, 2, 1, 1); instr_valid = 1'b1; step();
    instr_valid = 1'b0; step();
    ld_en = 1'b1; ld_addr = 2'd2; ld_data = 4'd9; step();
    ld_en = 1'b0;
    reg_is("wb_wins_r2", 2, 4'd6);

    // Reset with two queued entries and EX live
    hold = 1'b1;
    instr_in = mk(3'b011, 3, 1, 2); instr_valid = 1'b1; step();
    instr_in = mk(3'b000, 0, 1, 1); step();
    instr_in = mk(3'b000, 1, 2, 2); step();
    instr_valid = 1'b0; hold = 1'b0; step();
    hold = 1'b1;
    check("pre_rst_exv", {7'd0, ex_valid}, 8'd1);
    rst = 1'b1; #1;
    check("mid_rst_ready", {7'd0, instr_ready}, 8'd1);
    check("mid_rst_exv",   {7'd0, ex_valid}, 8'd0);
    check("mid_rst_sel",   {5'd0, sel}, 8'd0);
    check("mid_rst_rs",    {4'd0, rs}, 8'd0);
    check("mid_rst_rt",    {4'd0, rt}, 8'd0);
    check("mid_rst_dst",   {6'd0, wb_dst}, 8'd0);
    reg_is("mid_rst_r3", 3, 4'd0);
    step();
    rst = 1'b0; hold = 1'b0; step(); step();
    check("post_rst_exv", {7'd0, ex_valid}, 8'd0);
    reg_is("post_rst_r3", 3, 4'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
